// File: rtl/ysyx_22041211_mul_div_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master drives the request and consumes the result; the slave is the unit itself.
interface ysyx_22041211_mul_div_if #(
   parameter int unsigned DATA_LEN = 32
) ();
   logic                in_valid;
   logic                in_ready;
   logic [2:0]          md_op;
   logic [DATA_LEN-1:0] src1;
   logic [DATA_LEN-1:0] src2;
   logic                flush;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_LEN-1:0] result;
   logic                result_zero_o;
   logic                div_by_zero_o;

   modport master (
      output in_valid, md_op, src1, src2, flush, out_ready,
      input  in_ready, out_valid, result, result_zero_o, div_by_zero_o
   );

   modport slave (
      input  in_valid, md_op, src1, src2, flush, out_ready,
      output in_ready, out_valid, result, result_zero_o, div_by_zero_o
   );
endinterface

// File: rtl/ysyx_22041211_mul_div.sv
// Iterative RV-M style multiply/divide unit: one bit per cycle shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up on the final cycle.
module ysyx_22041211_mul_div #(
   parameter int unsigned DATA_LEN = 32
) (
   input logic                     clk,
   input logic                     rst_n,
   ysyx_22041211_mul_div_if.slave  md
);
   localparam int unsigned CntW = $clog2(DATA_LEN + 1);
   localparam logic [DATA_LEN-1:0] MinNeg = {1'b1, {(DATA_LEN - 1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e                state_q;
   logic [CntW-1:0]       cnt_q;
   logic [DATA_LEN:0]     hi_q;    // product high half (+carry) or partial remainder
   logic [DATA_LEN-1:0]   lo_q;    // multiplier being shifted out or quotient being shifted in
   logic [DATA_LEN-1:0]   opnd_q;  // multiplicand or divisor magnitude
   logic [2:0]            op_q;
   logic                  neg_q;
   logic [DATA_LEN-1:0]   result_q;
   logic                  zero_q;
   logic                  dbz_q;
   logic                  in_ready_q;
   logic                  out_valid_q;

   logic                  is_div, s1_signed, s2_signed, neg1, neg2, neg_new;
   logic                  div_zero, div_ovf;
   logic [DATA_LEN-1:0]   mag1, mag2, special_res;
   logic [DATA_LEN:0]     sum, rem_sh, hi_n;
   logic [DATA_LEN-1:0]   lo_n;
   logic [2*DATA_LEN-1:0] prod, prod_fix;
   logic [DATA_LEN-1:0]   div_val, div_fix, final_res;

   // Request decode and operand preparation.
   always_comb begin
      is_div    = md.md_op[2];
      s1_signed = is_div ? ~md.md_op[0] : (md.md_op[1:0] == 2'b01 || md.md_op[1:0] == 2'b10);
      s2_signed = is_div ? ~md.md_op[0] : (md.md_op[1:0] == 2'b01);
      neg1      = s1_signed & md.src1[DATA_LEN-1];
      neg2      = s2_signed & md.src2[DATA_LEN-1];
      mag1      = neg1 ? -md.src1 : md.src1;
      mag2      = neg2 ? -md.src2 : md.src2;
      neg_new   = (md.md_op == 3'b110) ? neg1 : (neg1 ^ neg2);
      div_zero  = is_div & (md.src2 == '0);
      div_ovf   = is_div & ~md.md_op[0] & (md.src1 == MinNeg) & (&md.src2);
      if (div_zero) begin
         special_res = md.md_op[1] ? md.src1 : '1;
      end else begin
         special_res = md.md_op[1] ? '0 : md.src1;
      end
   end

   // One iteration step and the final signed fix-up.
   always_comb begin
      sum    = lo_q[0] ? (hi_q + {1'b0, opnd_q}) : hi_q;
      rem_sh = {hi_q[DATA_LEN-1:0], lo_q[DATA_LEN-1]};
      if (op_q[2]) begin
         if (rem_sh >= {1'b0, opnd_q}) begin
            hi_n = rem_sh - {1'b0, opnd_q};
            lo_n = {lo_q[DATA_LEN-2:0], 1'b1};
         end else begin
            hi_n = rem_sh;
            lo_n = {lo_q[DATA_LEN-2:0], 1'b0};
         end
      end else begin
         hi_n = {1'b0, sum[DATA_LEN:1]};
         lo_n = {sum[0], lo_q[DATA_LEN-1:1]};
      end

      prod     = {hi_q[DATA_LEN-1:0], lo_q};
      prod_fix = neg_q ? -prod : prod;
      div_val  = op_q[1] ? hi_q[DATA_LEN-1:0] : lo_q;
      div_fix  = neg_q ? -div_val : div_val;
      if (op_q[2]) begin
         final_res = div_fix;
      end else if (op_q[1:0] == 2'b00) begin
         final_res = prod_fix[DATA_LEN-1:0];
      end else begin
         final_res = prod_fix[2*DATA_LEN-1:DATA_LEN];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         opnd_q      <= '0;
         op_q        <= '0;
         neg_q       <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         dbz_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else if (md.flush) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         zero_q      <= 1'b0;
         dbz_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (md.in_valid) begin
                  op_q       <= md.md_op;
                  neg_q      <= neg_new;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  if (div_zero || div_ovf) begin
                     // Corner cases bypass the iteration entirely.
                     result_q    <= special_res;
                     zero_q      <= (special_res == '0);
                     dbz_q       <= div_zero;
                     out_valid_q <= 1'b1;
                     state_q     <= StDone;
                  end else begin
                     hi_q    <= '0;
                     lo_q    <= is_div ? mag1 : mag2;
                     opnd_q  <= is_div ? mag2 : mag1;
                     state_q <= StCalc;
                  end
               end
            end
            StCalc: begin
               if (cnt_q == CntW'(DATA_LEN)) begin
                  result_q    <= final_res;
                  zero_q      <= (final_res == '0);
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  hi_q  <= hi_n;
                  lo_q  <= lo_n;
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StDone: begin
               if (md.out_ready) begin
                  zero_q      <= 1'b0;
                  dbz_q       <= 1'b0;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign md.in_ready      = in_ready_q;
   assign md.out_valid     = out_valid_q;
   assign md.result        = result_q;
   assign md.result_zero_o = zero_q;
   assign md.div_by_zero_o = dbz_q;
endmodule

// File: doc/ysyx_22041211_mul_div.md
YSYX_22041211_MUL_DIV -- requirements
Module: ysyx_22041211_MUL_DIV

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, meaning operand/result width; legal values are even and 8..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port md_op  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port src1  input  DATA_LEN  first operand (multiplicand/dividend).
REQ-008 SHALL have port src2  input  DATA_LEN  second operand (multiplier/divisor).
REQ-009 SHALL have port flush  input  1  abort any in-flight operation.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  DATA_LEN  operation result.
REQ-013 SHALL have port result_zero_o  output  1  result equals zero.
REQ-014 SHALL have port div_by_zero_o  output  1  completed op was DIV/DIVU/REM/REMU with src2 == 0.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 SHALL accept a request on a rising edge where in_valid & in_ready & ~flush, latching md_op, src1, src2; operands are ignored at all other times.
REQ-017 SHALL, on acceptance of a normal op, enter CALC and run exactly DATA_LEN iterations, one bit per cycle (shift-add multiply, restoring divide on magnitudes), then enter DONE; out_valid rises DATA_LEN+1 cycles after the accepting edge.
REQ-018 SHALL, for divide-class ops with src2 == 0, go IDLE -> DONE directly (out_valid on the cycle after acceptance) with DIV/DIVU result all ones, REM/REMU result = src1, div_by_zero_o = 1.
REQ-019 SHALL, for DIV/REM with src1 = most-negative value and src2 = all ones, go IDLE -> DONE directly with DIV result = src1, REM result = 0.
REQ-020 SHALL compute MUL as low DATA_LEN bits of product; MULH signed x signed, MULHSU signed src1 x unsigned src2, MULHU unsigned x unsigned, each returning high DATA_LEN bits of the 2*DATA_LEN product.
REQ-021 SHALL round signed division toward zero; remainder sign equals dividend sign; quotient negated when operand signs differ.
REQ-022 SHALL hold result, result_zero_o, div_by_zero_o stable in DONE until out_valid & out_ready, then return to IDLE on that edge; a new request is accepted no earlier than the following edge.
REQ-023 SHALL drive result_zero_o = (result == 0) and div_by_zero_o as in REQ-018 while out_valid; both 0 otherwise.
REQ-024 SHALL, when flush = 1 on an edge, go to IDLE from any state, discarding in-flight or pending result; flush has priority over acceptance and over out_ready.
REQ-025 SHALL keep result at its last value outside DONE; it carries no meaning when out_valid = 0.

Reset
REQ-026 SHALL, on rst_n low, immediately (without clock) force state IDLE, iteration counter 0, internal accumulators 0, result 0, out_valid 0, result_zero_o 0, div_by_zero_o 0; in_ready = 1 once rst_n is high.
REQ-027 SHALL, on reset asserted mid-CALC or in DONE, lose the operation with no result ever presented.

Verification (DATA_LEN = 32)
REQ-028 SHALL verify MUL src1=0xFFFFFFFF, src2=0x00000002 -> result 0xFFFFFFFE, out_valid exactly 33 cycles after accept; MULHU same operands -> 0x00000001; MULH -> 0xFFFFFFFF.
REQ-029 SHALL verify DIV src1=0xFFFFFFF9 (-7), src2=0x00000002 -> 0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1); DIVU 0x00000007/0x00000002 -> 0x00000003.
REQ-030 SHALL verify DIVU src2=0 with src1=0x12345678 -> result 0xFFFFFFFF, div_by_zero_o 1, out_valid one cycle after accept; REMU same -> 0x12345678.
REQ-031 SHALL verify DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in one cycle; REM same -> 0x00000000 with result_zero_o 1.
REQ-032 SHALL verify back-pressure: out_ready held 0 for 10 cycles in DONE -> result and out_valid stable, in_ready 0; out_ready pulse -> IDLE next edge.
REQ-033 SHALL verify flush asserted on cycle 5 of CALC, and rst_n pulsed low mid-CALC -> IDLE, out_valid never asserted, next request returns correct result.
